// File: rtl/dp_pkg.sv
// dp_pkg: shared constants for the register-file / ALU / RAM datapath.
//   - ALU opcode encodings (3 bits)
//   - write-back source select encodings (2 bits)
//   - register-file reset values
//   - data RAM power-up image
package dp_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;

  localparam logic [31:0] REG0_INIT = 32'h0000_FFFF;
  localparam logic [31:0] REG1_INIT = 32'hFFFF_0000;

  localparam logic [5:0]  RAM_INIT_ADDR_HI  = 6'd63;
  localparam logic [31:0] RAM_INIT_DATA_HI  = 32'hAAAA_AAAA;
  localparam logic [5:0]  RAM_INIT_ADDR_MID = 6'd41;
  localparam logic [31:0] RAM_INIT_DATA_MID = 32'hFFFF_FFFF;

  typedef logic [31:0] ram_image_t [64];

  // Power-up image of the data RAM; every word not listed is zero.
  function automatic ram_image_t ram_init_image();
    ram_image_t img;
    for (int i = 0; i < 64; i++) img[i] = 32'h0;
    img[RAM_INIT_ADDR_HI]  = RAM_INIT_DATA_HI;
    img[RAM_INIT_ADDR_MID] = RAM_INIT_DATA_MID;
    return img;
  endfunction

endpackage

// File: rtl/alu32.sv
// alu32: purely combinational 32-bit ALU with zero and signed-overflow flags.
// Ports:
//   a, b  in  32  operands
//   op    in  3   operation select (dp_pkg ALU_* encodings)
//   f     out 32  result
//   zf    out 1   result is zero (all ops)
//   of    out 1   signed overflow (ADD/SUB only, else 0)
module alu32
  import dp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] f,
  output logic        zf,
  output logic        of
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    f  = 32'h0;
    of = 1'b0;
    case (op)
      ALU_AND: f = a & b;
      ALU_OR:  f = a | b;
      ALU_XOR: f = a ^ b;
      ALU_NOR: f = ~(a | b);
      ALU_ADD: begin
        f  = sum;
        // like-signed operands producing an opposite-signed sum
        of = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        f  = diff;
        // unlike-signed operands where the result takes the sign of b
        of = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_SLT: f = {31'h0, ($signed(a) < $signed(b))};
      ALU_SLL: f = b << a[4:0];
      default: f = 32'h0;
    endcase
  end

  assign zf = (f == 32'h0);

endmodule

// File: rtl/regfile_alu_ram_datapath.sv
// regfile_alu_ram_datapath: 32x32 register file -> 32-bit ALU -> 64x32 data RAM,
// with a write-back mux feeding the ALU result or RAM read data back to the
// register file. Every internal node is exported for observation.
// Ports:
//   clk, Reset (sync, active-high)
//   Write_Reg, ALU_OP[2:0], Mem_Write, wr_data_s[1:0], rs/rt/rd[4:0]  controls
//   ZF, OF, F, A, B                 ALU observation
//   R_Data_A/B, R_Addr_A/B, W_Addr  register-file observation
//   W_Data                          write-back data
//   Mem_Addr, M_W_Data, M_R_Data    RAM observation (M_R_Data is registered)
module regfile_alu_ram_datapath
  import dp_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic        Write_Reg,
  input  logic [2:0]  ALU_OP,
  input  logic        Mem_Write,
  input  logic [1:0]  wr_data_s,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic        ZF,
  output logic        OF,
  output logic [31:0] M_R_Data,
  output logic [31:0] R_Data_A,
  output logic [31:0] R_Data_B,
  output logic [31:0] W_Data,
  output logic [5:0]  Mem_Addr,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] F,
  output logic [4:0]  R_Addr_A,
  output logic [4:0]  R_Addr_B,
  output logic [4:0]  W_Addr,
  output logic [31:0] M_W_Data
);

  logic [31:0] regs [32];
  // RAM is not touched by Reset, so its starting image comes from power-up.
  logic [31:0] ram [64] = ram_init_image();

  assign R_Data_A = regs[rs];
  assign R_Data_B = regs[rt];

  assign A        = R_Data_A;
  assign B        = R_Data_B;
  assign M_W_Data = R_Data_B;
  assign R_Addr_A = rs;
  assign R_Addr_B = rt;
  assign W_Addr   = rd;

  alu32 u_alu (
    .a  (A),
    .b  (B),
    .op (ALU_OP),
    .f  (F),
    .zf (ZF),
    .of (OF)
  );

  assign Mem_Addr = F[5:0];

  always_comb begin
    W_Data = 32'h0;
    case (wr_data_s)
      WB_ALU:  W_Data = F;
      WB_MEM:  W_Data = M_R_Data;
      default: W_Data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      regs[0] <= REG0_INIT;
      regs[1] <= REG1_INIT;
    end else if (Write_Reg) begin
      regs[rd] <= W_Data;
    end
  end

  // Read-first: the read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (Reset) begin
      M_R_Data <= 32'h0;
    end else begin
      M_R_Data <= ram[Mem_Addr];
      if (Mem_Write) ram[Mem_Addr] <= R_Data_B;
    end
  end

endmodule

// File: tb/tb_regfile_alu_ram_datapath.sv
module tb_regfile_alu_ram_datapath;
  import dp_pkg::*;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Write_Reg;
  logic [2:0]  ALU_OP;
  logic        Mem_Write;
  logic [1:0]  wr_data_s;
  logic [4:0]  rs, rt, rd;
  logic        ZF, OF;
  logic [31:0] M_R_Data, R_Data_A, R_Data_B, W_Data, A, B, F, M_W_Data;
  logic [5:0]  Mem_Addr;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_alu_ram_datapath dut (
    .clk       (clk),
    .Reset     (Reset),
    .Write_Reg (Write_Reg),
    .ALU_OP    (ALU_OP),
    .Mem_Write (Mem_Write),
    .wr_data_s (wr_data_s),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .ZF        (ZF),
    .OF        (OF),
    .M_R_Data  (M_R_Data),
    .R_Data_A  (R_Data_A),
    .R_Data_B  (R_Data_B),
    .W_Data    (W_Data),
    .Mem_Addr  (Mem_Addr),
    .A         (A),
    .B         (B),
    .F         (F),
    .R_Addr_A  (R_Addr_A),
    .R_Addr_B  (R_Addr_B),
    .W_Addr    (W_Addr),
    .M_W_Data  (M_W_Data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compute op(rs_i, rt_i), check the result, and commit it to rd_i.
  task automatic op_wr(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] dst, input logic [31:0] exp_f, input string tag);
    ALU_OP = op; rs = ra; rt = rb; rd = dst;
    wr_data_s = WB_ALU; Write_Reg = 1'b1;
    #1;
    chk(tag, F, exp_f);
    tick();
    Write_Reg = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] f;
    logic        zf;
  } logic_vec_t;

  logic_vec_t lvec [4];

  initial begin
    Reset = 1'b1; Write_Reg = 1'b0; Mem_Write = 1'b0; wr_data_s = WB_ALU;
    ALU_OP = ALU_ADD; rs = 5'd0; rt = 5'd1; rd = 5'd0;

    // reset state
    tick();
    chk("rst_rda",   R_Data_A, 32'h0000_FFFF);
    chk("rst_rdb",   R_Data_B, 32'hFFFF_0000);
    chk("rst_f",     F,        32'hFFFF_FFFF);
    chk("rst_zf",    {31'h0, ZF}, 32'h0);
    chk("rst_of",    {31'h0, OF}, 32'h0);
    chk("rst_maddr", {26'h0, Mem_Addr}, 32'd63);
    chk("rst_wdata", W_Data,   32'hFFFF_FFFF);
    chk("rst_mrd",   M_R_Data, 32'h0);

    // write ALU result to REG2; RAM[63] read
    Reset = 1'b0; Write_Reg = 1'b1; rd = 5'd2; wr_data_s = WB_ALU;
    tick();
    chk("rd63_mrd", M_R_Data, 32'hAAAA_AAAA);

    // write RAM data to REG3 while writing RAM[63]; read-first
    rd = 5'd3; wr_data_s = WB_MEM; Mem_Write = 1'b1;
    #1;
    chk("wb_mem_wdata", W_Data, 32'hAAAA_AAAA);
    tick();
    chk("rf_first_mrd", M_R_Data, 32'hAAAA_AAAA);

    // REG2 + REG3
    Write_Reg = 1'b0; Mem_Write = 1'b0; rs = 5'd2; rt = 5'd3; ALU_OP = ALU_ADD;
    #1;
    chk("reg2",       R_Data_A, 32'hFFFF_FFFF);
    chk("reg3",       R_Data_B, 32'hAAAA_AAAA);
    chk("add_f",      F,        32'hAAAA_AAA9);
    chk("add_zf",     {31'h0, ZF}, 32'h0);
    chk("add_of",     {31'h0, OF}, 32'h0);
    chk("add_maddr",  {26'h0, Mem_Addr}, 32'd41);
    chk("m_w_data",   M_W_Data, 32'hAAAA_AAAA);
    chk("a_pass",     A, 32'hFFFF_FFFF);
    chk("b_pass",     B, 32'hAAAA_AAAA);
    chk("addr_pass",  {17'h0, R_Addr_A, R_Addr_B, W_Addr}, {17'h0, 5'd2, 5'd3, 5'd3});
    tick();
    chk("rd41_mrd",   M_R_Data, 32'hFFFF_FFFF);
    chk("rd41_wdata", W_Data,   32'hFFFF_FFFF);
    wr_data_s = 2'd2; #1;
    chk("wb_sel2", W_Data, 32'h0);
    wr_data_s = 2'd3; #1;
    chk("wb_sel3", W_Data, 32'h0);
    wr_data_s = WB_ALU;

    // RAM[63] now holds FFFF0000
    rs = 5'd0; rt = 5'd0; ALU_OP = ALU_AND;
    tick();
    chk("ram63_new", M_R_Data, 32'hFFFF_0000);

    // logic ops: REG0=0000FFFF vs REG3=AAAAAAAA
    lvec[0] = '{ALU_AND, 32'h0000_AAAA, 1'b0};
    lvec[1] = '{ALU_OR,  32'hAAAA_FFFF, 1'b0};
    lvec[2] = '{ALU_XOR, 32'hAAAA_5555, 1'b0};
    lvec[3] = '{ALU_NOR, 32'h5555_0000, 1'b0};
    rs = 5'd0; rt = 5'd3;
    for (int i = 0; i < 4; i++) begin
      ALU_OP = lvec[i].op; #1;
      chk($sformatf("logic_f%0d", i), F, lvec[i].f);
      chk($sformatf("logic_of%0d", i), {31'h0, OF}, 32'h0);
    end
    // REG0 AND REG1 is zero
    rs = 5'd0; rt = 5'd1; ALU_OP = ALU_AND; #1;
    chk("and_zero_zf", {31'h0, ZF}, 32'h1);

    // build operands
    op_wr(ALU_SLT, 5'd2, 5'd0, 5'd4, 32'h0000_0001, "slt_neg_pos");
    op_wr(ALU_SLL, 5'd0, 5'd0, 5'd5, 32'h8000_0000, "sll_31");
    op_wr(ALU_NOR, 5'd5, 5'd6, 5'd7, 32'h7FFF_FFFF, "nor_mk");
    op_wr(ALU_ADD, 5'd4, 5'd4, 5'd8, 32'h0000_0002, "add_1_1");
    op_wr(ALU_SLL, 5'd8, 5'd4, 5'd9, 32'h0000_0004, "sll_1_2");

    // arithmetic boundaries
    ALU_OP = ALU_ADD; rs = 5'd7; rt = 5'd4; #1;
    chk("addov_f",  F, 32'h8000_0000);
    chk("addov_of", {31'h0, OF}, 32'h1);
    ALU_OP = ALU_SUB; rs = 5'd7; rt = 5'd7; #1;
    chk("subeq_f",  F, 32'h0);
    chk("subeq_zf", {31'h0, ZF}, 32'h1);
    chk("subeq_of", {31'h0, OF}, 32'h0);
    ALU_OP = ALU_SUB; rs = 5'd5; rt = 5'd4; #1;
    chk("subov_f",  F, 32'h7FFF_FFFF);
    chk("subov_of", {31'h0, OF}, 32'h1);
    ALU_OP = ALU_SLT; rs = 5'd2; rt = 5'd4; #1;
    chk("slt_m1_1", F, 32'h1);
    rs = 5'd4; rt = 5'd2; #1;
    chk("slt_1_m1",    F, 32'h0);
    chk("slt_1_m1_zf", {31'h0, ZF}, 32'h1);
    ALU_OP = ALU_SLL; rs = 5'd9; rt = 5'd4; #1;
    chk("sll_4_1", F, 32'h10);
    chk("sll_of",  {31'h0, OF}, 32'h0);

    // mid-run reset with both write enables high (would write REG0 and RAM[63])
    ALU_OP = ALU_OR; rs = 5'd0; rt = 5'd3; rd = 5'd0; wr_data_s = WB_ALU;
    Write_Reg = 1'b1; Mem_Write = 1'b1; Reset = 1'b1;
    tick();
    Reset = 1'b0; Write_Reg = 1'b0; Mem_Write = 1'b0;
    #1;
    chk("mrst_mrd",  M_R_Data, 32'h0);
    chk("mrst_reg0", R_Data_A, 32'h0000_FFFF);
    chk("mrst_reg3", R_Data_B, 32'h0);
    rs = 5'd2; rt = 5'd1; #1;
    chk("mrst_reg2", R_Data_A, 32'h0);
    chk("mrst_reg1", R_Data_B, 32'hFFFF_0000);
    rs = 5'd0; rt = 5'd0; ALU_OP = ALU_AND;
    tick();
    chk("mrst_ram63", M_R_Data, 32'hFFFF_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
